// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the pipelined data memory and its response pipe.
//   state_e           : top-level controller states (INIT clears the array,
//                       RUN serves requests)
//   MAX_READ_LATENCY  : deepest supported response pipeline
//   BYTE_W            : width of one write-enable lane
// ----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MAX_READ_LATENCY = 4;
  localparam int BYTE_W           = 8;

endpackage : mem_pkg

// File: rtl/mem_rsp_pipe.sv
// ----------------------------------------------------------------------------
// mem_rsp_pipe
// Fixed-latency response pipeline: a LATENCY-deep shift register carrying
// {valid, err, data}. Every valid entry leaves the last stage exactly LATENCY
// clock edges after it was loaded, so back-to-back inputs come out
// back-to-back and in order.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   valid_i/err_i/data_i   entry captured at the current edge
//   valid_o/err_o/data_o   last stage; err_o/data_o hold while valid_o=0
// ----------------------------------------------------------------------------
module mem_rsp_pipe
  import mem_pkg::*;
#(
  parameter int LATENCY    = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic                  err_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  // Out-of-range latencies are clamped into 1..MAX_READ_LATENCY.
  localparam int STAGES = (LATENCY < 1) ? 1 :
                          (LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : LATENCY;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic                  valid_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic                  valid_src;
    logic                  err_src;
    logic [DATA_WIDTH-1:0] data_src;

    if (g == 0) begin : g_head
      assign valid_src = valid_i;
      assign err_src   = err_i;
      assign data_src  = data_i;
    end else begin : g_body
      assign valid_src = g_stage[g-1].valid_q;
      assign err_src   = g_stage[g-1].err_q;
      assign data_src  = g_stage[g-1].data_q;
    end

    // Payload only moves with a valid entry, so the output stage keeps the
    // last response while bubbles pass through. Reset flushes the valid bits;
    // the output stage's payload is also cleared so the port reads zero
    // after reset.
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        if (g == STAGES - 1) begin
          err_q  <= 1'b0;
          data_q <= '0;
        end
      end else begin
        valid_q <= valid_src;
        if (valid_src) begin
          err_q  <= err_src;
          data_q <= data_src;
        end
      end
    end
  end

  assign valid_o = g_stage[STAGES-1].valid_q;
  assign err_o   = g_stage[STAGES-1].err_q;
  assign data_o  = g_stage[STAGES-1].data_q;

endmodule : mem_rsp_pipe

// File: rtl/data_memory_pipelined.sv
// ----------------------------------------------------------------------------
// data_memory_pipelined
// Word-addressed data memory for the MEM stage: single request port with a
// valid/ready handshake, byte-lane writes, fixed read latency, out-of-range
// detection and an optional zero-fill of the array after reset.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   req_valid    request present            req_ready  request can be taken
//   req_wr       1 write / 0 read           address    word address
//   data_in      write data                 byte_en    write lanes
//   rsp_valid    one pulse per accepted request, READ_LATENCY edges later
//   rsp_err      response address was >= DEPTH
//   data_out     read data (zero for writes and out-of-range reads)
// ----------------------------------------------------------------------------
module data_memory_pipelined
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1,
  parameter int INIT_CLEAR   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   data_out
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LANES = DATA_WIDTH / BYTE_W;

  state_e                state_q;
  logic [CNT_W-1:0]      init_cnt_q;
  logic                  req_ready_q;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  accept;
  logic                  in_range;
  logic                  init_we;
  logic [CNT_W-1:0]      word_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  assign accept   = req_valid & req_ready_q;
  // Full-width compare: addresses past DEPTH never alias onto low words.
  assign in_range = (address < ADDR_WIDTH'(DEPTH));
  assign word_idx = address[CNT_W-1:0];
  assign init_we  = rst_n & (state_q == INIT);

  // Read data is taken from the array as it stands at the accepting edge;
  // a write committed at any earlier edge is already visible.
  // NOTE: a combinational block assigns its output a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    rd_word = '0;
    if (!req_wr && in_range) begin
      rd_word = mem[word_idx];
    end
  end

  // Controller: INIT walks init_cnt over every word, then RUN forever.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= (INIT_CLEAR != 0) ? INIT : RUN;
      init_cnt_q  <= '0;
      req_ready_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          req_ready_q <= 1'b0;
          if (init_cnt_q == CNT_W'(DEPTH - 1)) begin
            state_q     <= RUN;
            req_ready_q <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Array write port: zero-fill during INIT, byte-lane writes in RUN.
  // NOTE: the array itself has no reset; contents are defined only by the
  // INIT clear or by writes, which keeps it mappable onto RAM.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_cnt_q] <= '0;
    end else if (accept && req_wr && in_range) begin
      for (int i = 0; i < LANES; i++) begin
        if (byte_en[i]) begin
          mem[word_idx][i*BYTE_W +: BYTE_W] <= data_in[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  mem_rsp_pipe #(
    .LATENCY   (READ_LATENCY),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rsp_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid_i(accept),
    .err_i  (~in_range),
    .data_i (rd_word),
    .valid_o(rsp_valid),
    .err_o  (rsp_err),
    .data_o (data_out)
  );

  assign req_ready = req_ready_q;

endmodule : data_memory_pipelined

// File: tb/tb_data_memory_pipelined.sv
// ----------------------------------------------------------------------------
// tb_data_memory_pipelined
// Directed bench for data_memory_pipelined (DEPTH=16, READ_LATENCY=3,
// INIT_CLEAR=1). Accepted requests push their expected response (data, err,
// arrival cycle) into a scoreboard queue; a monitor pops and compares on
// every rsp_valid. A small reference array tracks byte-lane writes.
// ----------------------------------------------------------------------------
module tb_data_memory_pipelined;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16;
  localparam int RL    = 3;
  localparam int BE_W  = DW / 8;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_wr    = 1'b0;
  logic [AW-1:0]   address   = '0;
  logic [DW-1:0]   data_in   = '0;
  logic [BE_W-1:0] byte_en   = '0;
  logic            req_ready;
  logic            rsp_valid;
  logic            rsp_err;
  logic [DW-1:0]   data_out;

  data_memory_pipelined #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .DEPTH       (DEPTH),
    .READ_LATENCY(RL),
    .INIT_CLEAR  (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr   (req_wr),
    .address  (address),
    .data_in  (data_in),
    .byte_en  (byte_en),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // Posedge count; read at negedges, so never racing the DUT.
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [DEPTH];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Called at a negedge; drives one request for one cycle. If the DUT is
  // ready the request is accepted at the next posedge, so its response is
  // expected RL posedges from now.
  task automatic issue(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BE_W-1:0] be);
    exp_t e;
    // NOTE: bench inputs are driven with blocking assignments at the
    // negedge, half a cycle clear of the sampling edge.
    req_valid = 1'b1;
    req_wr    = wr;
    address   = a;
    data_in   = d;
    byte_en   = be;
    if (req_ready) begin
      e.err  = (a >= AW'(DEPTH));
      e.data = '0;
      if (!e.err && !wr) e.data = model[a[3:0]];
      if (!e.err && wr) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) model[a[3:0]][i*8 +: 8] = d[i*8 +: 8];
        end
      end
      e.cyc = cyc + RL;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_scoreboard", 64'(sb.size()), 64'd0);
  endtask

  // Starts at the negedge rst_n is released; counts negedges with
  // req_ready low (bounded).
  task automatic count_ready_low(output int n);
    n = 0;
    while (!req_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("spurious_rsp_valid", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_data", 64'(data_out), 64'(e.data));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        check("rsp_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    int n;

    // Reset state
    model_clear();
    repeat (3) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_err", 64'(rsp_err), 64'd0);
    check("reset_data_out", 64'(data_out), 64'd0);

    // INIT length, then every word reads back as zero
    rst_n = 1'b1;
    count_ready_low(n);
    check("init_ready_low_cycles", 64'(n), 64'd16);
    check("ready_after_init", 64'(req_ready), 64'd1);
    for (int a = 0; a < DEPTH; a++) issue(1'b0, AW'(a), '0, '0);
    drain();

    // Full write then read-after-write on the next cycle
    issue(1'b1, 32'd5, 32'hDEADBEEF, 4'b1111);
    issue(1'b0, 32'd5, '0, '0);
    drain();
    repeat (2) @(negedge clk);
    check("hold_data_out", 64'(data_out), 64'hDEADBEEF);
    check("idle_rsp_valid", 64'(rsp_valid), 64'd0);

    // Partial byte-lane write
    issue(1'b1, 32'd5, 32'h11223344, 4'b0101);
    issue(1'b0, 32'd5, '0, '0);
    drain();

    // Out-of-range, top word, byte_en=0 no-op write
    issue(1'b0, 32'd16, '0, '0);
    issue(1'b1, 32'hFFFF_FFFF, 32'hCAFEF00D, 4'b1111);
    issue(1'b0, 32'd0, '0, '0);
    issue(1'b1, 32'd15, 32'hA5A55A5A, 4'b1111);
    issue(1'b0, 32'd15, '0, '0);
    issue(1'b1, 32'd2, 32'h12345678, 4'b0000);
    issue(1'b0, 32'd2, '0, '0);
    drain();

    // Back-to-back reads come out back-to-back, in order
    issue(1'b1, 32'd1, 32'h01010101, 4'b1111);
    issue(1'b1, 32'd2, 32'h02020202, 4'b1111);
    issue(1'b1, 32'd3, 32'h03030303, 4'b1111);
    issue(1'b0, 32'd1, '0, '0);
    issue(1'b0, 32'd2, '0, '0);
    issue(1'b0, 32'd3, '0, '0);
    drain();

    // Reset with two reads in flight: both responses are dropped
    issue(1'b0, 32'd1, '0, '0);
    issue(1'b0, 32'd2, '0, '0);
    rst_n = 1'b0;
    sb.delete();
    model_clear();
    repeat (2) @(negedge clk);
    check("flush_rsp_valid", 64'(rsp_valid), 64'd0);
    check("flush_req_ready", 64'(req_ready), 64'd0);

    // Release, then reset again while INIT is at word 7
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    check("mid_init_req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_ready_low(n);
    check("reinit_ready_low_cycles", 64'(n), 64'd16);

    // Array was cleared again
    issue(1'b0, 32'd1, '0, '0);
    issue(1'b0, 32'd3, '0, '0);
    issue(1'b0, 32'd5, '0, '0);
    issue(1'b0, 32'd15, '0, '0);
    drain();

    check("final_scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, %0d/%0d passed", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule : tb_data_memory_pipelined
